test_sequencer: RTL and testbench

- Sequences one memory test run. It drives the transaction stream toward the memory interface master and consumes addresses from the address generator.
- Per transaction: captures the generator's current address, issues a write, a read, or a write followed by a read to that address through a valid/ready command port, then advances the generator with a one-cycle pulse.
- Tracks outstanding reads and signals completion.
- Sits between the CSR block (start/params) and the memory command path, alongside the address generator.

---
 rtl/test_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_test_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_sequencer.sv
// ---------------------------------------------------------------------------
// test_sequencer
//
// Sequences one memory test run. It sits between the CSR block, which
// supplies the start pulse and run parameters, and the memory command path.
// It works alongside the address generator.
//
// For every transaction the sequencer:
//   - captures the generator's current address;
//   - issues a write, a read, or a write then a read to that address on a
//     valid/ready command port;
//   - pulses next_addr_en_o for one cycle to advance the generator.
//
// It also counts reads that are still in flight. When all N transactions
// are issued and every read has returned, it pulses done_o.
//
// Ports
//   clk_i           clock
//   rst_i           asynchronous, active-high reset
//   start_test_i    one-cycle start pulse (honoured only when idle)
//   test_param_i    [0] = transaction count N, [1][1:0] = op mode
//   next_addr_i     current address from the address generator
//   next_addr_en_o  one-cycle pulse: advance the generator
//   cmd_valid_o     command valid
//   cmd_ready_i     command accepted when valid and ready
//   cmd_we_o        1 = write, 0 = read
//   cmd_addr_o      command address
//   rd_done_i       one-cycle pulse per returned read
//   busy_o          run in progress
//   done_o          one-cycle pulse at the end of a run
//   trans_cnt_o     completed transactions in the current/last run
//   rsp_err_o       sticky: a read response arrived with none outstanding
// ---------------------------------------------------------------------------
module test_sequencer #(
  parameter int ADDR_W          = 28,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_test_i,
  input  logic [2:0][31:0]  test_param_i,
  input  logic [ADDR_W-1:0] next_addr_i,
  output logic              next_addr_en_o,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic              cmd_we_o,
  output logic [ADDR_W-1:0] cmd_addr_o,
  input  logic              rd_done_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       trans_cnt_o,
  output logic              rsp_err_o
);

  // Outstanding counter must be able to hold MAX_OUTSTANDING itself.
  localparam int              OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  localparam logic [1:0] MODE_WO  = 2'b00;  // write-only
  localparam logic [1:0] MODE_RO  = 2'b01;  // read-only
  localparam logic [1:0] MODE_WTR = 2'b10;  // write then read

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_FETCH,
    S_WR,
    S_RD,
    S_WAIT_RD,
    S_FIN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Run parameters, latched at start and frozen for the whole run.
  logic [31:0]       r_n;
  logic [1:0]        r_mode;

  logic [ADDR_W-1:0] r_cmd_addr;
  logic [31:0]       r_trans_cnt;
  logic              r_rsp_err;
  logic [OUT_W-1:0]  r_outstanding;

  logic              w_start;
  logic              w_cmd_valid;
  logic              w_hs;
  logic              w_rd_hs;
  logic              w_wr_hs;
  logic              w_txn_end;
  logic              w_last_txn;
  logic [1:0]        w_mode_in;
  logic [OUT_W-1:0]  w_outstanding_nxt;
  logic              w_rsp_err_set;

  // Only N and the two mode bits are used from the CSR parameter bank.
  logic              w_unused_params;
  assign w_unused_params = ^{test_param_i[2], test_param_i[1][31:2]};

  // ------------------------------------------------------------------
  // Handshake and transaction-end decode
  // ------------------------------------------------------------------
  assign w_start = start_test_i && (r_state == S_IDLE);

  // Mode 11 has no meaning of its own and runs as write-only.
  assign w_mode_in = (test_param_i[1][1:0] == 2'b11) ? MODE_WO
                                                     : test_param_i[1][1:0];

  // Reads are throttled at the outstanding limit. Because the check uses
  // the registered count, valid returns the cycle after a response frees
  // a slot.
  assign w_cmd_valid = (r_state == S_WR) ||
                       ((r_state == S_RD) && (r_outstanding != OUT_MAX));

  assign w_hs    = w_cmd_valid && cmd_ready_i;
  assign w_wr_hs = w_hs && (r_state == S_WR);
  assign w_rd_hs = w_hs && (r_state == S_RD);

  // A write ends the transaction unless a read to the same address follows.
  assign w_txn_end  = w_rd_hs || (w_wr_hs && (r_mode != MODE_WTR));
  assign w_last_txn = ((r_trans_cnt + 32'd1) == r_n);

  // ------------------------------------------------------------------
  // Outstanding-read accounting
  // ------------------------------------------------------------------
  always_comb begin
    w_outstanding_nxt = r_outstanding;
    w_rsp_err_set     = 1'b0;
    // A response with nothing in flight is a protocol error.
    // The counter is left at zero rather than underflowing.
    if (rd_done_i && (r_outstanding == '0)) begin
      w_rsp_err_set = 1'b1;
    end
    if (w_rd_hs && !rd_done_i) begin
      w_outstanding_nxt = r_outstanding + 1'b1;
    end else if (!w_rd_hs && rd_done_i && (r_outstanding != '0)) begin
      w_outstanding_nxt = r_outstanding - 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_test_i) begin
          w_state_nxt = S_SETTLE;
        end
      end
      // The generator loads its start address on the start edge.
      // Wait one cycle before sampling it.
      S_SETTLE: begin
        w_state_nxt = (r_n == 32'd0) ? S_FIN : S_FETCH;
      end
      S_FETCH: begin
        w_state_nxt = (r_mode == MODE_RO) ? S_RD : S_WR;
      end
      S_WR: begin
        if (w_hs) begin
          if (r_mode == MODE_WTR) begin
            w_state_nxt = S_RD;
          end else begin
            w_state_nxt = w_last_txn ? S_WAIT_RD : S_FETCH;
          end
        end
      end
      S_RD: begin
        if (w_hs) begin
          w_state_nxt = w_last_txn ? S_WAIT_RD : S_FETCH;
        end
      end
      // A response arriving this cycle that empties the count is enough
      // to finish.
      S_WAIT_RD: begin
        if (w_outstanding_nxt == '0) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: outputs
  // ------------------------------------------------------------------
  always_comb begin
    cmd_valid_o    = w_cmd_valid;
    cmd_we_o       = (r_state == S_WR);
    next_addr_en_o = w_txn_end;
    busy_o         = (r_state != S_IDLE);
    done_o         = (r_state == S_FIN);
  end

  assign cmd_addr_o  = r_cmd_addr;
  assign trans_cnt_o = r_trans_cnt;
  assign rsp_err_o   = r_rsp_err;

  // ------------------------------------------------------------------
  // Run parameters, command address, counters, error flag
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_n           <= '0;
      r_mode        <= MODE_WO;
      r_cmd_addr    <= '0;
      r_trans_cnt   <= '0;
      r_rsp_err     <= 1'b0;
      r_outstanding <= '0;
    end else begin
      r_outstanding <= w_outstanding_nxt;

      if (w_start) begin
        r_n         <= test_param_i[0];
        r_mode      <= w_mode_in;
        r_trans_cnt <= '0;
      end else if (w_txn_end) begin
        r_trans_cnt <= r_trans_cnt + 32'd1;
      end

      // A new run clears the sticky error. An error seen on that same
      // cycle still wins.
      r_rsp_err <= (w_start ? 1'b0 : r_rsp_err) | w_rsp_err_set;

      // The address is held through WR and RD, so it is stable until the
      // handshake completes.
      if (r_state == S_FETCH) begin
        r_cmd_addr <= next_addr_i;
      end
    end
  end

endmodule

// File: tb/tb_test_sequencer.sv
`timescale 1ns/1ps
module tb_test_sequencer;

  localparam int ADDR_W  = 28;
  localparam int MAX_OUT = 8;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              start_test_i;
  logic [2:0][31:0]  test_param_i;
  logic [ADDR_W-1:0] next_addr_i;
  logic              next_addr_en_o;
  logic              cmd_valid_o;
  logic              cmd_ready_i;
  logic              cmd_we_o;
  logic [ADDR_W-1:0] cmd_addr_o;
  logic              rd_done_i;
  logic              busy_o;
  logic              done_o;
  logic [31:0]       trans_cnt_o;
  logic              rsp_err_o;

  always #5 clk = ~clk;

  test_sequencer #(.ADDR_W(ADDR_W), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_test_i   (start_test_i),
    .test_param_i   (test_param_i),
    .next_addr_i    (next_addr_i),
    .next_addr_en_o (next_addr_en_o),
    .cmd_valid_o    (cmd_valid_o),
    .cmd_ready_i    (cmd_ready_i),
    .cmd_we_o       (cmd_we_o),
    .cmd_addr_o     (cmd_addr_o),
    .rd_done_i      (rd_done_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .trans_cnt_o    (trans_cnt_o),
    .rsp_err_o      (rsp_err_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard of expected commands {we, addr}.
  logic [ADDR_W:0] exp_q[$];

  // Controls written by the main sequence only.
  int              ready_mode = 0;   // 0 low, 1 high, 2 random 30%
  bit              resp_auto  = 1'b0;
  int              resp_delay = 5;
  int              man_total  = 0;
  bit              chk_en_rd  = 1'b0;
  logic [ADDR_W-1:0] gen_base = '0;

  // State owned by the monitor/responder process.
  int              cyc = 0;
  int              hs_cnt = 0;
  int              en_cnt = 0;
  int              done_cnt = 0;
  int              done_cyc = 0;
  int              last_rd_cyc = 0;
  int              man_sent = 0;
  int              hs_cyc[$];
  int              due_q[$];
  logic [ADDR_W-1:0] gen_nxt;
  bit              prev_stall = 1'b0;
  logic            prev_we;
  logic [ADDR_W-1:0] prev_addr;

  // Monitor (negedge) + generator model + responder (posedge+1).
  initial begin
    cmd_ready_i = 1'b0;
    rd_done_i   = 1'b0;
    next_addr_i = '0;
    gen_nxt     = '0;
    forever begin
      @(negedge clk);
      gen_nxt = next_addr_i;
      if (start_test_i && !busy_o) gen_nxt = gen_base;
      else if (next_addr_en_o)     gen_nxt = next_addr_i + 1'b1;

      if (rst_i) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 64'(cmd_valid_o), 64'd1);
          chk("stall_we",    64'(cmd_we_o),    64'(prev_we));
          chk("stall_addr",  64'(cmd_addr_o),  64'(prev_addr));
        end
        if (cmd_valid_o && cmd_ready_i) begin
          hs_cnt++;
          hs_cyc.push_back(cyc);
          chk("cmd_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            chk("cmd", 64'({cmd_we_o, cmd_addr_o}), 64'(exp_q.pop_front()));
          end
          if (!cmd_we_o && resp_auto) due_q.push_back(cyc + resp_delay);
        end
        if (next_addr_en_o) begin
          en_cnt++;
          chk("en_with_hs", 64'(cmd_valid_o && cmd_ready_i), 64'd1);
          if (chk_en_rd) chk("en_on_read", 64'(cmd_we_o), 64'd0);
        end
        prev_stall = cmd_valid_o && !cmd_ready_i;
        prev_we    = cmd_we_o;
        prev_addr  = cmd_addr_o;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (rd_done_i) last_rd_cyc = cyc;

      @(posedge clk);
      cyc++;
      #1;
      next_addr_i = gen_nxt;
      case (ready_mode)
        0:       cmd_ready_i = 1'b0;
        1:       cmd_ready_i = 1'b1;
        default: cmd_ready_i = ($urandom_range(99) < 30);
      endcase
      if (man_sent < man_total) begin
        rd_done_i = 1'b1;
        man_sent++;
      end else if (due_q.size() != 0 && due_q[0] <= cyc) begin
        rd_done_i = 1'b1;
        void'(due_q.pop_front());
      end else begin
        rd_done_i = 1'b0;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic start_run(input logic [31:0] n, input logic [1:0] mode,
                           input logic [ADDR_W-1:0] base);
    gen_base        = base;
    test_param_i[0] = n;
    test_param_i[1] = {30'd0, mode};
    start_test_i    = 1'b1;
    tick(1);
    start_test_i    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      tick(1);
      k++;
    end
    chk({tag, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
  endtask

  initial begin
    int h0, e0, d0, i0;

    rst_i        = 1'b1;
    start_test_i = 1'b0;
    test_param_i = '0;
    tick(3);
    chk("rst_busy",  64'(busy_o),         64'd0);
    chk("rst_done",  64'(done_o),         64'd0);
    chk("rst_valid", 64'(cmd_valid_o),    64'd0);
    chk("rst_we",    64'(cmd_we_o),       64'd0);
    chk("rst_addr",  64'(cmd_addr_o),     64'd0);
    chk("rst_en",    64'(next_addr_en_o), 64'd0);
    chk("rst_cnt",   64'(trans_cnt_o),    64'd0);
    chk("rst_err",   64'(rsp_err_o),      64'd0);
    rst_i = 1'b0;
    tick(2);
    chk("idle_busy", 64'(busy_o), 64'd0);

    // Write-only, N=3, ready always high.
    ready_mode = 1;
    exp_q.push_back({1'b1, 28'h10});
    exp_q.push_back({1'b1, 28'h11});
    exp_q.push_back({1'b1, 28'h12});
    h0 = hs_cnt; e0 = en_cnt; d0 = done_cnt; i0 = hs_cyc.size();
    start_run(32'd3, 2'b00, 28'h10);
    chk("t1_busy_settle", 64'(busy_o), 64'd1);
    wait_done("t1", 100);
    chk("t1_cnt",     64'(trans_cnt_o),  64'd3);
    chk("t1_hs",      64'(hs_cnt - h0),  64'd3);
    chk("t1_en",      64'(en_cnt - e0),  64'd3);
    chk("t1_q_empty", 64'(exp_q.size()), 64'd0);
    chk("t1_gap0",    64'(hs_cyc[i0+1] - hs_cyc[i0]),   64'd2);
    chk("t1_gap1",    64'(hs_cyc[i0+2] - hs_cyc[i0+1]), 64'd2);
    chk("t1_done_at", 64'(done_cyc - hs_cyc[i0+2]),     64'd2);
    chk("t1_busy_end", 64'(busy_o), 64'd0);
    tick(3);
    chk("t1_done_once", 64'(done_cnt - d0),  64'd1);
    chk("t1_cnt_hold",  64'(trans_cnt_o),    64'd3);

    // Write-then-read, N=2, reads answered 5 cycles later.
    resp_auto = 1'b1; resp_delay = 5; chk_en_rd = 1'b1;
    exp_q.push_back({1'b1, 28'h10});
    exp_q.push_back({1'b0, 28'h10});
    exp_q.push_back({1'b1, 28'h11});
    exp_q.push_back({1'b0, 28'h11});
    e0 = en_cnt;
    start_run(32'd2, 2'b10, 28'h10);
    wait_done("t2", 200);
    chk("t2_cnt",       64'(trans_cnt_o),            64'd2);
    chk("t2_en",        64'(en_cnt - e0),            64'd2);
    chk("t2_q_empty",   64'(exp_q.size()),           64'd0);
    chk("t2_done_after_rd", 64'(done_cyc - last_rd_cyc), 64'd1);
    chk("t2_err",       64'(rsp_err_o),              64'd0);
    chk_en_rd = 1'b0;

    // Read-only, N=12, responses withheld: throttled at 8 outstanding.
    resp_auto = 1'b0;
    for (int i = 0; i < 12; i++) exp_q.push_back({1'b0, 28'h40 + 28'(i)});
    h0 = hs_cnt; e0 = en_cnt;
    start_run(32'd12, 2'b01, 28'h40);
    tick(40);
    chk("t3_hs_max",    64'(hs_cnt - h0),  64'd8);
    chk("t3_valid_low", 64'(cmd_valid_o),  64'd0);
    chk("t3_busy",      64'(busy_o),       64'd1);
    chk("t3_cnt8",      64'(trans_cnt_o),  64'd8);
    man_total = man_total + 1;
    tick(8);
    chk("t3_hs_plus1",  64'(hs_cnt - h0),  64'd9);
    chk("t3_valid_low2", 64'(cmd_valid_o), 64'd0);
    resp_auto = 1'b1; resp_delay = 4;
    man_total = man_total + 8;
    wait_done("t3", 400);
    chk("t3_cnt",     64'(trans_cnt_o),  64'd12);
    chk("t3_en",      64'(en_cnt - e0),  64'd12);
    chk("t3_q_empty", 64'(exp_q.size()), 64'd0);
    chk("t3_err",     64'(rsp_err_o),    64'd0);

    // Write-then-read, N=6, random ready, plus an ignored mid-run start.
    ready_mode = 2; resp_delay = 3;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({1'b1, 28'h80 + 28'(i)});
      exp_q.push_back({1'b0, 28'h80 + 28'(i)});
    end
    d0 = done_cnt;
    start_run(32'd6, 2'b10, 28'h80);
    tick(15);
    chk("t4_busy_mid", 64'(busy_o), 64'd1);
    test_param_i[0] = 32'd1;
    test_param_i[1] = 32'd1;
    start_test_i = 1'b1;
    tick(1);
    start_test_i = 1'b0;
    wait_done("t4", 3000);
    chk("t4_cnt",       64'(trans_cnt_o),   64'd6);
    chk("t4_q_empty",   64'(exp_q.size()),  64'd0);
    chk("t4_err",       64'(rsp_err_o),     64'd0);
    chk("t4_done_once", 64'(done_cnt - d0), 64'd1);

    // N=0: two busy cycles, done pulse, no commands.
    ready_mode = 1;
    h0 = hs_cnt;
    start_run(32'd0, 2'b00, 28'h0);
    chk("t5_busy0", 64'(busy_o), 64'd1);
    chk("t5_done0", 64'(done_o), 64'd0);
    tick(1);
    chk("t5_busy1", 64'(busy_o), 64'd1);
    chk("t5_done1", 64'(done_o), 64'd1);
    tick(1);
    chk("t5_busy2", 64'(busy_o), 64'd0);
    chk("t5_done2", 64'(done_o), 64'd0);
    chk("t5_no_cmd", 64'(hs_cnt - h0), 64'd0);
    chk("t5_cnt",    64'(trans_cnt_o), 64'd0);

    // Stray response in IDLE, cleared by next start; reset mid-WR.
    man_total = man_total + 1;
    tick(3);
    chk("t6_err_set", 64'(rsp_err_o), 64'd1);
    ready_mode = 0;
    exp_q.push_back({1'b1, 28'h20});
    start_run(32'd1, 2'b00, 28'h20);
    chk("t6_err_clr", 64'(rsp_err_o), 64'd0);
    tick(3);
    chk("t6_wr_valid", 64'(cmd_valid_o), 64'd1);
    chk("t6_wr_we",    64'(cmd_we_o),    64'd1);
    chk("t6_wr_addr",  64'(cmd_addr_o),  64'h20);
    d0 = done_cnt;
    rst_i = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(cmd_valid_o),    64'd0);
    chk("t6_rst_we",    64'(cmd_we_o),       64'd0);
    chk("t6_rst_addr",  64'(cmd_addr_o),     64'd0);
    chk("t6_rst_busy",  64'(busy_o),         64'd0);
    chk("t6_rst_done",  64'(done_o),         64'd0);
    chk("t6_rst_en",    64'(next_addr_en_o), 64'd0);
    chk("t6_rst_cnt",   64'(trans_cnt_o),    64'd0);
    tick(2);
    rst_i = 1'b0;
    exp_q.delete();
    tick(3);
    chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
    chk("t6_idle",    64'(busy_o),        64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
